// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: word RAM plus MMIO TX FIFO, status and cycle counter.
// Optional misaligned-access trapping is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ce_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]           ram [0:(1 << ADDR_WIDTH) - 1];
    logic [7:0]            fifo_mem [0:FIFO_DEPTH - 1];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  misaligned;
    logic [31:0]           cycle_cnt;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  in_mmio;
    logic [3:0]            offset;
    logic                  bad_align;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  ram_we;
    logic                  txdata_we;
    logic                  status_we;
    logic                  cycle_we;
    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  push_ok;
    logic                  push_drop;
    logic [31:0]           status_word;
    logic                  unused_addr_bits;

    assign word_idx         = data_addr_i[ADDR_WIDTH+1:2];
    assign in_mmio          = (data_addr_i[31:28] == MMIO_BASE[31:28]);
    assign offset           = data_addr_i[3:0];
    assign unused_addr_bits = &{1'b0, data_addr_i[27:ADDR_WIDTH+2]};

`ifdef DMEM_MISALIGN_CHECK_EN
    assign bad_align = (data_addr_i[1:0] != 2'b00);
`else
    assign bad_align = 1'b0;
`endif

    // Writes are gated by rst so an edge racing reset assertion cannot land.
    assign wr_ok     = rst & data_ce_i & data_we_i & ~bad_align;
    assign rd_ok     = data_ce_i & ~data_we_i;
    assign ram_we    = wr_ok & ~in_mmio;
    assign txdata_we = wr_ok & in_mmio & (offset == 4'h0);
    assign status_we = wr_ok & in_mmio & (offset == 4'h4);
    assign cycle_we  = wr_ok & in_mmio & (offset == 4'h8);

    assign empty      = (count == '0);
    assign full       = (count == CW'(FIFO_DEPTH));
    assign tx_valid_o = ~empty;
    assign tx_data_o  = empty ? 8'h00 : fifo_mem[rd_ptr];
    assign pop        = tx_valid_o & tx_ready_i;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still fits.
    assign push_ok    = txdata_we & (~full | pop);
    assign push_drop  = txdata_we & full & ~pop;

    assign status_word = {16'h0000, 8'(count), 4'h0, misaligned, overflow, full, empty};

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[word_idx] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= data_i[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop);
            if (push_drop) begin
                overflow <= 1'b1;
            end else if (status_we && data_i[2]) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misaligned <= 1'b0;
        end else if (data_ce_i && bad_align) begin
            misaligned <= 1'b1;
        end else if (status_we && data_i[3]) begin
            misaligned <= 1'b0;
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    // A load takes priority over the increment; counting resumes from the next edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
        end else if (cycle_we) begin
            cycle_cnt <= data_i;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    always_comb begin
        data_o = 32'h0000_0000;
        if (rd_ok) begin
            if (bad_align) begin
                data_o = 32'hDEAD_BEEF;
            end else if (!in_mmio) begin
                data_o = ram[word_idx];
            end else begin
                case (offset)
                    4'h4:    data_o = status_word;
                    4'h8:    data_o = cycle_cnt;
                    default: data_o = 32'h0000_0000;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed scoreboard bench for dmem_responder.
module tb_dmem_responder;
    localparam int          AW  = 10;
    localparam logic [31:0] MB  = 32'h1000_0000;
    localparam logic [31:0] TXD = MB;
    localparam logic [31:0] STS = MB + 32'h4;
    localparam logic [31:0] CYC = MB + 32'h8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;

    int n_assert = 0;
    int n_fail = 0;
    logic [31:0] rdq [$];
    logic [7:0]  txq [$];

    dmem_responder #(.ADDR_WIDTH(AW), .MMIO_BASE(MB), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .data_ce_i(ce), .data_we_i(we), .data_addr_i(addr),
        .data_i(wdata), .data_o(rdata), .tx_valid_o(tx_valid), .tx_data_o(tx_data),
        .tx_ready_i(tx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ce = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        ce = 1'b1; we = 1'b0; addr = a;
        rdq.push_back(exp);
        @(negedge clk);
        check(tag, rdata, rdq.pop_front());
        @(posedge clk); #1;
        ce = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b);
        wr(TXD, {24'h0, b});
        txq.push_back(b);
    endtask

    task automatic drain(input string tag);
        logic [31:0] exp;
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!tx_valid) break;
            exp = (txq.size() > 0) ? {24'h0, txq.pop_front()} : 32'hxxxx_xxxx;
            check(tag, {24'h0, tx_data}, exp);
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        tx_ready = 1'b0;
        check({tag, "_left"}, txq.size(), 32'd0);
        check({tag, "_valid"}, {31'h0, tx_valid}, 32'd0);
    endtask

    initial begin
        #2 rst = 1'b0;
        #2;
        check("rst_valid", {31'h0, tx_valid}, 32'd0);
        check("rst_data", {24'h0, tx_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("idle_data_o", rdata, 32'd0);
        @(posedge clk); #1;
        rd("status_rst", STS, 32'h0000_0001);

        wr(32'h0000_0010, 32'hA5A5_0001);
        rd("ram_rd", 32'h0000_0010, 32'hA5A5_0001);
        rd("ram_alias", 32'h0000_0010 + (32'd4 << AW), 32'hA5A5_0001);
        wr(32'h0000_0020, 32'h1234_5678);
        rd("ram_rd2", 32'h0000_0020, 32'h1234_5678);
        rd("ram_keep", 32'h0000_0010, 32'hA5A5_0001);
        rd("txdata_rd", TXD, 32'd0);
        rd("bad_off", MB + 32'hC, 32'd0);

        for (int b = 1; b <= 8; b++) push_tx(8'(b));
        wr(TXD, 32'h0000_0009);
        rd("status_ovf", STS, 32'h0000_0806);
        drain("drain1");
        rd("status_after1", STS, 32'h0000_0005);
        wr(STS, 32'h0000_0004);
        rd("ovf_clear", STS, 32'h0000_0001);

        for (int b = 8'h11; b <= 8'h18; b++) push_tx(8'(b));
        rd("status_full", STS, 32'h0000_0802);
        ce = 1'b1; we = 1'b1; addr = TXD; wdata = 32'h0000_0055; tx_ready = 1'b1;
        @(negedge clk);
        check("pushpop_head", {24'h0, tx_data}, {24'h0, txq.pop_front()});
        txq.push_back(8'h55);
        @(posedge clk); #1;
        ce = 1'b0; we = 1'b0; tx_ready = 1'b0;
        rd("status_pushpop", STS, 32'h0000_0802);
        drain("drain2");
        rd("status_after2", STS, 32'h0000_0001);

        wr(CYC, 32'hFFFF_FFFE);
        rd("cyc0", CYC, 32'hFFFF_FFFE);
        rd("cyc1", CYC, 32'hFFFF_FFFF);
        rd("cyc2", CYC, 32'h0000_0000);

        wr(32'h0000_0030, 32'hC0C0_0001);
`ifdef DMEM_MISALIGN_CHECK_EN
        wr(32'h0000_0032, 32'h7777_0000);
        rd("mis_ram", 32'h0000_0030, 32'hC0C0_0001);
        rd("mis_status", STS, 32'h0000_0009);
        rd("mis_read", 32'h0000_0033, 32'hDEAD_BEEF);
        wr(STS, 32'h0000_0008);
        rd("mis_clear", STS, 32'h0000_0001);
`else
        wr(32'h0000_0032, 32'h7777_0000);
        rd("lowbits_ram", 32'h0000_0030, 32'h7777_0000);
        rd("lowbits_status", STS, 32'h0000_0001);
`endif

        push_tx(8'hA1);
        push_tx(8'hA2);
        push_tx(8'hA3);
        tx_ready = 1'b1;
        @(negedge clk);
        check("mid_head", {24'h0, tx_data}, {24'h0, txq.pop_front()});
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", {31'h0, tx_valid}, 32'd0);
        check("mid_rst_data", {24'h0, tx_data}, 32'd0);
        ce = 1'b1; we = 1'b0; addr = STS;
        #1;
        check("mid_rst_status", rdata, 32'h0000_0001);
        ce = 1'b0; tx_ready = 1'b0;
        txq.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rd("ram_after_rst", 32'h0000_0010, 32'hA5A5_0001);
        rd("status_after_rst", STS, 32'h0000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
